// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control stage.
//   state_t       : FSM state encoding (also exported on the debug port)
//   CS_MAX/SEC_MAX: terminal BCD values of the centisecond/second counters
//   bin_to_bcd2   : elaboration-time conversion of a 0..99 integer to two BCD digits
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  localparam logic [7:0] CS_MAX  = 8'h99;
  localparam logic [7:0] SEC_MAX = 8'h59;

  function automatic logic [7:0] bin_to_bcd2(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd2_cnt.sv
// Two-digit BCD counter that wraps at MAX.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   inc      : advance by one this cycle
//   clr      : synchronous clear to 00 (wins over inc)
//   q        : current value, two BCD digits
//   carry    : high in the cycle an increment wraps MAX -> 00
module bcd2_cnt #(
  parameter logic [7:0] MAX = 8'h99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] q,
  output logic       carry
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 8'h00;
    end else if (inc) begin
      if (q_q == MAX) begin
        q_d = 8'h00;
      end else if (q_q[3:0] == 4'd9) begin
        q_d = {q_q[7:4] + 4'd1, 4'd0};
      end else begin
        q_d = {q_q[7:4], q_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= 8'h00;
    else     q_q <= q_d;
  end

  assign q     = q_q;
  assign carry = inc && !clr && (q_q == MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM and MM:SS.CC BCD time-keeping.
// Ports:
//   iCLK, iRESET       : clock, asynchronous active-high reset
//   iSTART_STOP/iCLEAR/iLAP : single-cycle command pulses
//   iTICK_10MS         : 10 ms tick from the tick generator
//   oCK_RUN, oCK_RST   : run / reset controls to the tick generator
//   oCS_BCD/oSEC_BCD/oMIN_BCD : displayed time (lap register while in LAP)
//   oLAP_ACT           : display frozen
//   oOVF               : one-cycle pulse when time wraps to 00:00.00
//   oDBG_STATE         : current FSM state, for observation only
// Interface: there is no valid/ready handshake. Every input is a level sampled
// on the iCLK edge; a command acts on the single edge where its pulse is high.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MIN_LIMIT = 60
) (
  input  logic       iCLK,
  input  logic       iRESET,
  input  logic       iSTART_STOP,
  input  logic       iCLEAR,
  input  logic       iLAP,
  input  logic       iTICK_10MS,
  output logic       oCK_RUN,
  output logic       oCK_RST,
  output logic [7:0] oCS_BCD,
  output logic [7:0] oSEC_BCD,
  output logic [7:0] oMIN_BCD,
  output logic       oLAP_ACT,
  output logic       oOVF,
  output logic [1:0] oDBG_STATE
);

  localparam logic [7:0] MIN_MAX = bin_to_bcd2(unsigned'(MIN_LIMIT - 1));

  state_t     state_q, state_d;
  logic       lap_cap;
  logic       tick_en, time_clr;
  logic [7:0] cs_q, sec_q, min_q;
  logic       cs_carry, sec_carry, min_carry;
  logic [7:0] lap_cs_q, lap_sec_q, lap_min_q;
  logic       ovf_q;

  // Ticks while halted are dropped: the generator may emit spurious ticks
  // while parked at terminal count.
  assign tick_en  = iTICK_10MS && (state_q == ST_RUN || state_q == ST_LAP);
  assign time_clr = (state_q == ST_PAUSE) && iCLEAR;

  bcd2_cnt #(.MAX(CS_MAX)) u_cs (
    .clk(iCLK), .rst(iRESET), .inc(tick_en), .clr(time_clr),
    .q(cs_q), .carry(cs_carry)
  );

  bcd2_cnt #(.MAX(SEC_MAX)) u_sec (
    .clk(iCLK), .rst(iRESET), .inc(cs_carry), .clr(time_clr),
    .q(sec_q), .carry(sec_carry)
  );

  bcd2_cnt #(.MAX(MIN_MAX)) u_min (
    .clk(iCLK), .rst(iRESET), .inc(sec_carry), .clr(time_clr),
    .q(min_q), .carry(min_carry)
  );

  // Priority iCLEAR > iSTART_STOP > iLAP among the commands that mean
  // something in the current state; a command ignored in a state does not
  // block a lower-priority one.
  always_comb begin
    state_d = state_q;
    lap_cap = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (iSTART_STOP) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (iSTART_STOP) begin
          state_d = ST_PAUSE;
        end else if (iLAP) begin
          state_d = ST_LAP;
          lap_cap = 1'b1;
        end
      end
      ST_LAP: begin
        if (iSTART_STOP) state_d = ST_PAUSE;
        else if (iLAP)   state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (iCLEAR)           state_d = ST_IDLE;
        else if (iSTART_STOP) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q   <= ST_IDLE;
      lap_cs_q  <= 8'h00;
      lap_sec_q <= 8'h00;
      lap_min_q <= 8'h00;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      // Lap holds the time before this edge's tick is applied.
      if (lap_cap) begin
        lap_cs_q  <= cs_q;
        lap_sec_q <= sec_q;
        lap_min_q <= min_q;
      end
      ovf_q <= min_carry;
    end
  end

  assign oCK_RUN    = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign oCK_RST    = (state_q == ST_IDLE);
  assign oLAP_ACT   = (state_q == ST_LAP);
  assign oOVF       = ovf_q;
  assign oDBG_STATE = state_q;

  assign oCS_BCD  = oLAP_ACT ? lap_cs_q  : cs_q;
  assign oSEC_BCD = oLAP_ACT ? lap_sec_q : sec_q;
  assign oMIN_BCD = oLAP_ACT ? lap_min_q : min_q;

endmodule
